// File: rtl/acc16_pkg.sv
// acc16 shared types and constants.
// Frame accumulator state enum and default widths.
package acc16_pkg;

    localparam int ACC_WIDTH = 16;
    localparam int ACC_CNT_W = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } acc_state_t;

endpackage

// File: rtl/acc16_stage_prefix_add16.sv
// 16-bit Ladner-Fischer parallel-prefix adder.
// Purely combinational, no carry-in.
module prefix_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p0;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] gn;
    logic [15:0] pn;
    logic [15:0] c;
    logic [3:0]  j;

    // Four prefix levels; at level k each bit with bit k of its index set
    // merges with the top bit of the preceding 2^k-aligned group.
    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        gn = g;
        pn = p;
        j  = '0;
        for (int k = 0; k < 4; k++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < 16; i++) begin
                if (((i >> k) & 1) == 1) begin
                    j     = 4'(((i >> k) << k) - 1);
                    gn[i] = g[i] | (p[i] & g[j]);
                    pn[i] = p[i] & p[j];
                end
            end
            g = gn;
            p = pn;
        end
        c    = {g[14:0], 1'b0};
        sum  = p0 ^ c;
        cout = g[15];
    end

endmodule

// File: rtl/acc16_stage.sv
// Frame accumulator: sums operands until in_last, then holds
// the result (sum, sticky carry, saturating count) until taken.
module acc16_stage
    import acc16_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH,
    parameter int CNT_W = ACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    acc_state_t       state;
    logic [WIDTH-1:0] acc;
    logic             cout_sticky;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    prefix_add16 u_add (
        .a    (acc),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Frame FSM with registered handshake flags and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            cout_sticky <= 1'b0;
            count       <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            unique case (state)
                ACC: begin
                    if (in_valid) begin
                        acc         <= add_sum;
                        cout_sticky <= cout_sticky | add_cout;
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                        end
                        if (in_last) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= ACC;
                        acc         <= '0;
                        cout_sticky <= 1'b0;
                        count       <= '0;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: begin
                    state <= ACC;
                end
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_cout  = cout_sticky;
    assign out_count = count;

endmodule

// File: tb/tb_acc16_stage.sv
// Directed bench for acc16_stage: table of frames plus
// hold, reset and saturation sequences.
module tb_acc16_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic [7:0]  out_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0][15:0] d;
        int               n;
        logic [15:0]      s;
        logic             c;
        logic [7:0]       cnt;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    acc16_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_count (out_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        check("beat_in_ready", in_ready, 1);
        check("beat_out_valid_low", out_valid, 0);
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0;
    endtask

    task automatic expect_res(input string name, input logic [15:0] s,
                              input logic c, input logic [7:0] n);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_sum"}, out_sum, s);
        check({name, "_cout"}, out_cout, c);
        check({name, "_count"}, out_count, n);
    endtask

    task automatic handshake(input string name);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({name, "_hs_valid"}, out_valid, 0);
        check({name, "_hs_in_ready"}, in_ready, 1);
        check({name, "_hs_count"}, out_count, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{{16'h0003, 16'h0002, 16'h0001}, 3, 16'h0006, 1'b0, 8'd3};
        vecs[1] = '{{16'h0000, 16'h0001, 16'hFFFF}, 2, 16'h0000, 1'b1, 8'd2};
        vecs[2] = '{{16'h0000, 16'h0000, 16'hABCD}, 1, 16'hABCD, 1'b0, 8'd1};
        vecs[3] = '{{16'h0000, 16'h8000, 16'h8000}, 2, 16'h0000, 1'b1, 8'd2};
        vecs[4] = '{{16'h0002, 16'hFFFF, 16'hFFFF}, 3, 16'h0000, 1'b1, 8'd3};
        vecs[5] = '{{16'h0F0F, 16'h4321, 16'h1234}, 3, 16'h6464, 1'b0, 8'd3};
        vecs[6] = '{{16'h0000, 16'h0000, 16'h0000}, 1, 16'h0000, 1'b0, 8'd1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_count", out_count, 0);

        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < vecs[i].n; b++) begin
                beat(vecs[i].d[b], b == vecs[i].n - 1);
            end
            expect_res($sformatf("vec%0d", i), vecs[i].s, vecs[i].c,
                       vecs[i].cnt);
            handshake($sformatf("vec%0d", i));
        end

        beat(16'h0007, 1'b1);
        expect_res("hold0", 16'h0007, 1'b0, 8'd1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'hFFFF;
            in_last  = 1'b1;
            tick;
            expect_res($sformatf("hold%0d", k + 1), 16'h0007, 1'b0, 8'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0;
        handshake("hold");
        beat(16'h0010, 1'b1);
        expect_res("after_hold", 16'h0010, 1'b0, 8'd1);
        handshake("after_hold");

        beat(16'h1234, 1'b0);
        beat(16'h1111, 1'b0);
        check("mid_partial_sum", out_sum, 16'h2345);
        check("mid_partial_count", out_count, 2);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_count", out_count, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("mid_rst_no_result", out_valid, 0);
        end
        beat(16'h0005, 1'b1);
        expect_res("post_rst", 16'h0005, 1'b0, 8'd1);
        handshake("post_rst");

        beat(16'hFFFF, 1'b0);
        beat(16'h0004, 1'b1);
        expect_res("done_pre", 16'h0003, 1'b1, 8'd2);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick;
        rst       = 1'b0;
        out_ready = 1'b0;
        check("done_rst_valid", out_valid, 0);
        check("done_rst_in_ready", in_ready, 1);
        check("done_rst_sum", out_sum, 0);
        check("done_rst_cout", out_cout, 0);
        for (int k = 0; k < 2; k++) begin
            tick;
            check("done_rst_no_result", out_valid, 0);
        end

        for (int k = 0; k < 300; k++) begin
            beat(16'h0001, k == 299);
        end
        expect_res("sat", 16'h012C, 1'b0, 8'd255);
        handshake("sat");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc16_stage.md
ACC16_STAGE -- requirements
Module: acc16_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, which is the operand and sum width and is fixed at 16 for this release.
REQ-002 The block SHALL have parameter CNT_W, default 8, which is the width of the beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream operand is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the operand; bit WIDTH-1 is the MSB, unsigned.
REQ-008 The block SHALL have port in_last, input, 1 bit: marks the final operand of a frame.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the frame result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port out_sum, output, WIDTH bits: the modulo-2^WIDTH sum of the frame's operands.
REQ-012 The block SHALL have port out_cout, output, 1 bit: sticky OR of every adder carry-out within the frame.
REQ-013 The block SHALL have port out_count, output, CNT_W bits: the number of operands in the frame, saturating.

Function
REQ-014 The block SHALL implement FSM states ACC (accepting operands) and DONE (holding the result).
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in ACC.
REQ-016 On an accepted beat the block SHALL update acc <= acc + in_data (WIDTH bits, wrap), cout_sticky <= cout_sticky | carry, and count <= count+1, with count saturating at 2^CNT_W-1.
REQ-017 The first beat of a frame SHALL add to acc = 0, cout_sticky = 0 and count = 0.
REQ-018 An accepted beat with in_last=1 SHALL move the FSM ACC->DONE, and out_valid SHALL rise on the following cycle (latency 1 cycle from the last beat).
REQ-019 In DONE, out_sum, out_cout and out_count SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 An out_valid and out_ready handshake SHALL clear acc, cout_sticky and count and move DONE->ACC, with in_ready=1 on the next cycle; there is no same-cycle bypass.
REQ-021 in_data and in_last SHALL be ignored when no handshake occurs.
REQ-022 A frame of one beat SHALL produce out_sum = in_data, out_cout = 0 and out_count = 1.
REQ-023 out_sum, out_cout and out_count SHALL be driven directly from registers, and their values while out_valid=0 are don't-care (the registered values are shown).

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL enter ACC with acc=0, cout_sticky=0, count=0, out_valid=0 and in_ready=1 on the next cycle.
REQ-025 Reset asserted mid-frame or in DONE SHALL discard all partial or pending results, and no result for that frame SHALL ever be emitted.
REQ-026 Reset SHALL take priority over any simultaneous handshake.

Structure
REQ-027 A shared package acc16_pkg SHALL hold the state enum type (ACC, DONE) and the constants ACC_WIDTH=16 and ACC_CNT_W=8.
REQ-028 The addition SHALL be performed by one instantiated sub-module, prefix_add16: a combinational 16-bit Ladner-Fischer parallel-prefix adder with inputs a[15:0] and b[15:0], outputs sum[15:0] and cout, and no carry-in.
REQ-029 The sub-module SHALL take a = acc register and b = in_data directly, so the only path through it is input/register to register.

Verification
REQ-030 Frame 0x0001, 0x0002, 0x0003(last) -> out_valid 1 cycle after the last beat, out_sum=0x0006, out_cout=0, out_count=3.
REQ-031 Frame 0xFFFF, 0x0001(last) -> out_sum=0x0000, out_cout=1, out_count=2.
REQ-032 Single beat 0xABCD(last) -> out_sum=0xABCD, out_cout=0, out_count=1.
REQ-033 Hold out_ready=0 for 5 cycles after the result -> outputs stable and in_ready=0 throughout; after the handshake, frame 0x0010(last) -> out_sum=0x0010.
REQ-034 Assert rst after 2 beats (0x1234, 0x1111) -> no result emitted; then frame 0x0005(last) -> out_sum=0x0005, out_count=1.
REQ-035 300 beats of 0x0001, last on the 300th -> out_sum=0x012C, out_cout=0, out_count=255 (saturated).
